// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants and the pattern-to-nibble decoder.
package seg7_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [SEG_W-1:0] SEG7_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG7_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG7_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG7_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG7_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG7_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG7_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG7_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG7_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG7_9     = 7'h18;
    localparam logic [SEG_W-1:0] SEG7_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG7_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG7_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG7_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG7_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG7_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

    // Decoded digit payload
    typedef struct packed {
        logic                invalid;
        logic [NIBBLE_W-1:0] nibble;
    } seg7_dec_t;

    // Map an active-low pattern back to its hex value; non-glyphs flag invalid
    function automatic seg7_dec_t seg7_to_nibble(input logic [SEG_W-1:0] pat);
        seg7_dec_t d;
        d.invalid = 1'b0;
        d.nibble  = 4'h0;
        case (pat)
            SEG7_0:  d.nibble = 4'h0;
            SEG7_1:  d.nibble = 4'h1;
            SEG7_2:  d.nibble = 4'h2;
            SEG7_3:  d.nibble = 4'h3;
            SEG7_4:  d.nibble = 4'h4;
            SEG7_5:  d.nibble = 4'h5;
            SEG7_6:  d.nibble = 4'h6;
            SEG7_7:  d.nibble = 4'h7;
            SEG7_8:  d.nibble = 4'h8;
            SEG7_9:  d.nibble = 4'h9;
            SEG7_A:  d.nibble = 4'hA;
            SEG7_B:  d.nibble = 4'hB;
            SEG7_C:  d.nibble = 4'hC;
            SEG7_D:  d.nibble = 4'hD;
            SEG7_E:  d.nibble = 4'hE;
            SEG7_F:  d.nibble = 4'hF;
            default: d.invalid = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Synchronizes the scanned display bus and emits one commit per stable digit.
module seg7_sync_filter
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [SEG_W-1:0]                       seg_n,
    input  logic [DIGITS-1:0]                      dig_sel_n,
    output logic                                   commit,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] commit_idx,
    output logic [SEG_W-1:0]                       commit_pat
);

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES);
    localparam int unsigned CNT_MAX = STABLE_CYCLES - 1;

    logic [SEG_W-1:0]  seg_s1, seg_s2, seg_prev;
    logic [DIGITS-1:0] sel_s1, sel_s2, sel_prev;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DIGITS-1:0] sel_act_c;
    logic              onehot_c;
    logic              same_c;
    logic              hit_c;
    logic [IDX_W-1:0]  idx_c;

    // Two-flop synchronizer plus previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            seg_prev <= '0;
            sel_s1   <= '0;
            sel_s2   <= '0;
            sel_prev <= '0;
        end else begin
            seg_s1   <= seg_n;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            sel_s1   <= dig_sel_n;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
        end
    end

    // Qualification, stability counting and digit index encoding
    always_comb begin
        sel_act_c = ~sel_s2;
        onehot_c  = (sel_act_c != '0) && ((sel_act_c & (sel_act_c - DIGITS'(1))) == '0);
        same_c    = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
        cnt_nx    = '0;
        hit_c     = 1'b0;
        if (onehot_c && same_c) begin
            if (cnt == CNT_W'(CNT_MAX)) begin
                cnt_nx = cnt;
            end else begin
                cnt_nx = cnt + CNT_W'(1);
                hit_c  = (cnt == CNT_W'(CNT_MAX - 1));
            end
        end
        idx_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sel_act_c[i]) idx_c = IDX_W'(i);
        end
    end

    // Counter state and registered commit strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            commit     <= 1'b0;
            commit_idx <= '0;
            commit_pat <= '0;
        end else begin
            cnt        <= cnt_nx;
            commit     <= hit_c;
            commit_idx <= idx_c;
            commit_pat <= seg_s2;
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a scanned 7-segment bus into frames of hex nibbles with valid/ready output.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEG_W-1:0]           seg_n,
    input  logic [DIGITS-1:0]          dig_sel_n,
    output logic [NIBBLE_W*DIGITS-1:0] value,
    output logic [DIGITS-1:0]          invalid_mask,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       overrun
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = NIBBLE_W * DIGITS;

    logic              commit;
    logic [IDX_W-1:0]  commit_idx;
    logic [SEG_W-1:0]  commit_pat;
    seg7_dec_t         dec_c;

    logic [VAL_W-1:0]  shadow_val, shadow_val_nx;
    logic [DIGITS-1:0] shadow_inv, shadow_inv_nx;
    logic [DIGITS-1:0] captured, captured_nx;
    logic [VAL_W-1:0]  value_nx;
    logic [DIGITS-1:0] invalid_mask_nx;
    logic              frame_valid_nx;
    logic              overrun_nx;
    logic              transfer_c;

    seg7_sync_filter #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .dig_sel_n  (dig_sel_n),
        .commit     (commit),
        .commit_idx (commit_idx),
        .commit_pat (commit_pat)
    );

    // Shadow update, frame transfer and handshake next-state
    always_comb begin
        dec_c           = seg7_to_nibble(commit_pat);
        transfer_c      = (&captured) && (!frame_valid || frame_ready);
        shadow_val_nx   = shadow_val;
        shadow_inv_nx   = shadow_inv;
        captured_nx     = transfer_c ? '0 : captured;
        value_nx        = value;
        invalid_mask_nx = invalid_mask;
        frame_valid_nx  = frame_valid && !frame_ready;
        overrun_nx      = 1'b0;
        if (transfer_c) begin
            value_nx        = shadow_val;
            invalid_mask_nx = shadow_inv;
            frame_valid_nx  = 1'b1;
        end
        if (commit) begin
            shadow_val_nx[NIBBLE_W*int'(commit_idx) +: NIBBLE_W] = dec_c.nibble;
            shadow_inv_nx[commit_idx] = dec_c.invalid;
            captured_nx[commit_idx]   = 1'b1;
            // a commit alongside a transfer starts the next frame, so it never overruns
            overrun_nx = captured[commit_idx] && !transfer_c;
        end
    end

    // Shadow, captured mask and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val   <= '0;
            shadow_inv   <= '0;
            captured     <= '0;
            value        <= '0;
            invalid_mask <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            shadow_val   <= shadow_val_nx;
            shadow_inv   <= shadow_inv_nx;
            captured     <= captured_nx;
            value        <= value_nx;
            invalid_mask <= invalid_mask_nx;
            frame_valid  <= frame_valid_nx;
            overrun      <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scoreboard bench for seg7_scan_decoder (4 digits, 4-sample filter).
module tb_seg7_scan_decoder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SC     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel_n;
    logic [15:0] value;
    logic [3:0]  invalid_mask;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;
    int frames_seen = 0;

    logic [15:0] exp_val_q[$];
    logic [3:0]  exp_mask_q[$];

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_n        (seg_n),
        .dig_sel_n    (dig_sel_n),
        .value        (value),
        .invalid_mask (invalid_mask),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Hand-copied glyph table
    function automatic logic [6:0] g(input int h);
        case (h)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h18; 10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        logic [3:0] one;
        one = 4'b0001;
        dig_sel_n = ~(one << d);
        seg_n     = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show_twohot(input int d, input logic [6:0] pat, input int n);
        logic [3:0] two;
        two = 4'b0011;
        dig_sel_n = ~(two << d);
        seg_n     = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dig_sel_n = 4'hF;
        seg_n     = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3, input int dwell);
        show(0, p0, dwell);
        show(1, p1, dwell);
        show(2, p2, dwell);
        show(3, p3, dwell);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] m);
        exp_val_q.push_back(v);
        exp_mask_q.push_back(m);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_val_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drain"}, 32'(exp_val_q.size()), 32'd0);
    endtask

    // Monitor: compares presented frames against the scoreboard queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (overrun) ovr_cnt++;
                if (frame_valid) begin
                    if (exp_val_q.size() == 0) begin
                        check("unexpected_frame", 32'(frame_valid), 32'd0);
                    end else if (frame_ready) begin
                        check("frame_value", 32'(value), 32'(exp_val_q[0]));
                        check("frame_mask", 32'(invalid_mask), 32'(exp_mask_q[0]));
                        void'(exp_val_q.pop_front());
                        void'(exp_mask_q.pop_front());
                        frames_seen++;
                    end else begin
                        check("held_value", 32'(value), 32'(exp_val_q[0]));
                        check("held_mask", 32'(invalid_mask), 32'(exp_mask_q[0]));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int o;
        rst_n       = 1'b0;
        frame_ready = 1'b1;
        dig_sel_n   = 4'hF;
        seg_n       = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'd0);
        check("rst_mask", 32'(invalid_mask), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Basic scan "1","2","3","4"
        expect_frame(16'h4321, 4'b0000);
        scan(g(1), g(2), g(3), g(4), 8);
        idle(12);
        drain("basic");

        // Non-glyph patterns on digits 0 and 2
        expect_frame(16'hF010, 4'b0101);
        scan(7'h55, g(1), 7'h7F, g(15), 8);
        idle(12);
        drain("invalid");

        // Too-short dwell commits nothing; a following full scan yields one clean frame
        o = ovr_cnt;
        scan(g(5), g(6), g(7), g(8), 3);
        idle(12);
        expect_frame(16'hCBA9, 4'b0000);
        scan(g(9), g(10), g(11), g(12), 8);
        idle(12);
        drain("short_dwell");
        check("short_dwell_overrun", 32'(ovr_cnt - o), 32'd0);

        // Long two-hot ghosting between digits never commits
        o = ovr_cnt;
        expect_frame(16'h8670, 4'b0000);
        show(0, g(0), 8);
        show_twohot(0, 7'h00, 6);
        show(1, g(7), 8);
        show_twohot(1, 7'h00, 6);
        show(2, g(6), 8);
        show_twohot(2, 7'h00, 6);
        show(3, g(8), 8);
        idle(12);
        drain("twohot");
        check("twohot_overrun", 32'(ovr_cnt - o), 32'd0);

        // Back-pressure: first frame held, third scan overruns, then back-to-back transfer
        frame_ready = 1'b0;
        o = ovr_cnt;
        expect_frame(16'h1234, 4'b0000);
        scan(g(4), g(3), g(2), g(1), 8);
        idle(12);
        check("bp_valid_first", 32'(frame_valid), 32'd1);
        scan(g(10), g(10), g(10), g(10), 8);
        expect_frame(16'h5077, 4'b0000);
        scan(g(7), g(7), g(0), g(5), 8);
        idle(12);
        check("bp_overrun_count", 32'(ovr_cnt - o), 32'd4);
        check("bp_valid_held", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_back_to_back", 32'(frame_valid), 32'd1);
        drain("backpressure");

        // Reset after two of four digits discards the partial frame
        show(0, g(1), 8);
        show(1, g(2), 8);
        idle(10);
        rst_n = 1'b0;
        #2;
        check("midrst_value", 32'(value), 32'd0);
        check("midrst_mask", 32'(invalid_mask), 32'd0);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        o = ovr_cnt;
        expect_frame(16'hFEDC, 4'b0000);
        scan(g(12), g(13), g(14), g(15), 8);
        idle(12);
        drain("post_reset");
        check("post_reset_overrun", 32'(ovr_cnt - o), 32'd0);

        idle(10);
        check("frames_seen", 32'(frames_seen), 32'd7);
        check("queue_empty", 32'(exp_val_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
